// File: rtl/hbus_arb_if.sv
// Hart-side and memory-side bus bundle for the shared memory-bus arbiter.
// The arbiter uses the master modport; the hart/memory environment uses slave.
interface hbus_arb_if #(
  parameter int N_HART = 2,
  parameter int LINE_W = 128
);
  // Hart side
  logic [N_HART*64-1:0]     h_addr;
  logic [N_HART-1:0]        h_rd;
  logic [N_HART-1:0]        h_wr;
  logic [N_HART*LINE_W-1:0] h_data_out;
  logic [LINE_W-1:0]        h_data_in;
  logic [N_HART-1:0]        h_dv;
  logic [63:0]              h_inv_addr;
  logic [N_HART-1:0]        h_inv;
  logic [N_HART-1:0]        h_amo_req;
  logic [N_HART-1:0]        h_amo_ack;
  // Memory side
  logic [63:0]              m_addr;
  logic                     m_rd;
  logic                     m_wr;
  logic [LINE_W-1:0]        m_data_out;
  logic [LINE_W-1:0]        m_data_in;
  logic                     m_dv;

  modport master (
    input  h_addr, h_rd, h_wr, h_data_out, h_amo_req, m_data_in, m_dv,
    output h_data_in, h_dv, h_inv_addr, h_inv, h_amo_ack,
           m_addr, m_rd, m_wr, m_data_out
  );

  modport slave (
    output h_addr, h_rd, h_wr, h_data_out, h_amo_req, m_data_in, m_dv,
    input  h_data_in, h_dv, h_inv_addr, h_inv, h_amo_ack,
           m_addr, m_rd, m_wr, m_data_out
  );
endinterface

// File: rtl/hbus_arb.sv
// Shared memory-bus arbiter: serialises hart line transactions round-robin
// onto one memory port, owns the global AMO lock and broadcasts a
// write-invalidate to all other harts after every write.
module hbus_arb #(
  parameter int N_HART = 2,
  parameter int LINE_W = 128
) (
  input  logic       clk,
  input  logic       rst,
  hbus_arb_if.master bus
);

  localparam int IW = (N_HART > 1) ? $clog2(N_HART) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     gnt_q, gnt_d;
  logic              is_wr_q, is_wr_d;
  logic [63:0]       addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              lock_vld_q, lock_vld_d;
  logic [IW-1:0]     lock_own_q, lock_own_d;

  logic [N_HART-1:0] elig;
  logic              pick_vld;
  logic [IW-1:0]     pick_idx;
  logic [63:0]       addr_sel;
  logic [LINE_W-1:0] wdata_sel;
  logic              wr_sel;
  logic              amo_any;
  logic [IW-1:0]     amo_idx;

  // Per-hart eligibility and per-hart response strobes
  for (genvar gi = 0; gi < N_HART; gi++) begin : g_hart
    assign elig[gi] = (bus.h_rd[gi] | bus.h_wr[gi]) &
                      (~lock_vld_q | (lock_own_q == IW'(gi)));
    assign bus.h_dv[gi]      = (state_q == S_DONE) && (gnt_q == IW'(gi));
    assign bus.h_inv[gi]     = (state_q == S_DONE) && is_wr_q && (gnt_q != IW'(gi));
    assign bus.h_amo_ack[gi] = lock_vld_q && (lock_own_q == IW'(gi));
  end

  assign bus.m_rd       = (state_q == S_RD);
  assign bus.m_wr       = (state_q == S_WR);
  assign bus.m_addr     = addr_q;
  assign bus.m_data_out = wdata_q;
  assign bus.h_data_in  = rdata_q;
  assign bus.h_inv_addr = addr_q;

  // Round-robin pick: first eligible at or above rr_ptr, else wrap to the lowest
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = 0; i < N_HART; i++) begin
      if (!pick_vld && elig[i] && (IW'(i) >= rr_ptr_q)) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
    for (int i = 0; i < N_HART; i++) begin
      if (!pick_vld && elig[i]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(i);
      end
    end
  end

  // Select the picked hart's address, write data and write flag
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    wr_sel    = 1'b0;
    for (int i = 0; i < N_HART; i++) begin
      if (pick_idx == IW'(i)) begin
        addr_sel  = bus.h_addr[64*i +: 64];
        wdata_sel = bus.h_data_out[LINE_W*i +: LINE_W];
        wr_sel    = bus.h_wr[i];
      end
    end
  end

  // Lowest-index AMO requester
  always_comb begin
    amo_any = 1'b0;
    amo_idx = '0;
    for (int i = N_HART - 1; i >= 0; i--) begin
      if (bus.h_amo_req[i]) begin
        amo_any = 1'b1;
        amo_idx = IW'(i);
      end
    end
  end

  // AMO lock: release takes one cycle, a new grant needs the lock already free
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    if (lock_vld_q) begin
      if (!bus.h_amo_req[lock_own_q]) lock_vld_d = 1'b0;
    end else if (amo_any) begin
      lock_vld_d = 1'b1;
      lock_own_d = amo_idx;
    end
  end

  // Bus FSM next state; grant and latches stay fixed for the whole transaction
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          addr_d  = addr_sel;
          wdata_d = wdata_sel;
          is_wr_d = wr_sel;
          state_d = wr_sel ? S_WR : S_RD;
        end
      end
      S_RD: begin
        if (bus.m_dv) begin
          rdata_d = bus.m_data_in;
          state_d = S_DONE;
        end
      end
      S_WR: begin
        if (bus.m_dv) state_d = S_DONE;
      end
      S_DONE: begin
        rr_ptr_d = (gnt_q == IW'(N_HART - 1)) ? '0 : gnt_q + IW'(1);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      is_wr_q    <= is_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
    end
  end

endmodule

// File: tb/tb_hbus_arb.sv
// Directed, table-driven bench for hbus_arb with two harts.
module tb_hbus_arb;

  localparam int N = 2;
  localparam int LW = 128;
  localparam logic [63:0]   A0 = 64'h8000_0040;
  localparam logic [63:0]   A1 = 64'h0000_1000;
  localparam logic [LW-1:0] RLINE = {16{8'hA5}};
  localparam logic [LW-1:0] WLINE = {16{8'h5A}};
  localparam logic [LW-1:0] OLINE = {16{8'h33}};

  logic clk;
  logic rst;

  hbus_arb_if #(.N_HART(N), .LINE_W(LW)) bus ();

  hbus_arb #(.N_HART(N), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [1:0]  amo;
    logic        mdv;
    logic        exp_mrd;
    logic        exp_mwr;
    logic [1:0]  exp_hdv;
    logic [1:0]  exp_hinv;
    logic [1:0]  exp_ack;
    logic [63:0] exp_addr;
    logic        chk_rdata;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int row = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] rd, input logic [1:0] wr,
                              input logic [1:0] amo, input logic mdv,
                              input logic mrd, input logic mwr,
                              input logic [1:0] hdv, input logic [1:0] hinv,
                              input logic [1:0] ack, input logic [63:0] addr,
                              input logic rdat);
    vec_t v;
    v.rd = rd; v.wr = wr; v.amo = amo; v.mdv = mdv;
    v.exp_mrd = mrd; v.exp_mwr = mwr; v.exp_hdv = hdv; v.exp_hinv = hinv;
    v.exp_ack = ack; v.exp_addr = addr; v.chk_rdata = rdat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
    end
  endtask

  // Drive one record, clock it in, then compare the registered response
  task automatic apply(input vec_t v);
    bus.h_rd      = v.rd;
    bus.h_wr      = v.wr;
    bus.h_amo_req = v.amo;
    bus.m_dv      = v.mdv;
    @(posedge clk);
    #1;
    $display("row %0d rd=%b wr=%b amo=%b mdv=%b -> m_rd=%b m_wr=%b h_dv=%b h_inv=%b ack=%b",
             row, v.rd, v.wr, v.amo, v.mdv, bus.m_rd, bus.m_wr, bus.h_dv, bus.h_inv,
             bus.h_amo_ack);
    chk("m_rd", LW'(bus.m_rd), LW'(v.exp_mrd));
    chk("m_wr", LW'(bus.m_wr), LW'(v.exp_mwr));
    chk("h_dv", LW'(bus.h_dv), LW'(v.exp_hdv));
    chk("h_inv", LW'(bus.h_inv), LW'(v.exp_hinv));
    chk("h_amo_ack", LW'(bus.h_amo_ack), LW'(v.exp_ack));
    if (v.exp_mrd || v.exp_mwr) chk("m_addr", LW'(bus.m_addr), LW'(v.exp_addr));
    if (v.exp_mwr) chk("m_data_out", bus.m_data_out, WLINE);
    if (v.exp_hinv != 2'b00) chk("h_inv_addr", LW'(bus.h_inv_addr), LW'(v.exp_addr));
    if (v.chk_rdata) chk("h_data_in", bus.h_data_in, RLINE);
    row++;
  endtask

  task automatic zero_check(input string tag);
    $display("row %0d %s: all-outputs-zero check", row, tag);
    chk("rst_h_dv", LW'(bus.h_dv), '0);
    chk("rst_h_inv", LW'(bus.h_inv), '0);
    chk("rst_ack", LW'(bus.h_amo_ack), '0);
    chk("rst_m_rd", LW'(bus.m_rd), '0);
    chk("rst_m_wr", LW'(bus.m_wr), '0);
    chk("rst_h_data_in", bus.h_data_in, '0);
    chk("rst_h_inv_addr", LW'(bus.h_inv_addr), '0);
    chk("rst_m_addr", LW'(bus.m_addr), '0);
    chk("rst_m_data_out", bus.m_data_out, '0);
    row++;
  endtask

  initial begin
    // Single read: m_dv arrives 4 cycles after m_rd rises
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(2'b01, 2'b00, 2'b00, 1'b0, 1, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 1'b1, 0, 0, 2'b01, 2'b00, 2'b00, A0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    // Write-invalidate from hart1
    tbl.push_back(mk(2'b00, 2'b10, 2'b00, 1'b0, 0, 1, 2'b00, 2'b00, 2'b00, A1, 0));
    tbl.push_back(mk(2'b00, 2'b10, 2'b00, 1'b1, 0, 0, 2'b10, 2'b01, 2'b00, A1, 0));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, A1, 0));
    // Round-robin with zero-latency memory: 3-cycle period, order 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 1, 0, 2'b00, 2'b00, 2'b00,
                       (t % 2 == 0) ? A0 : A1, 0));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 0, 0, (t % 2 == 0) ? 2'b01 : 2'b10,
                       2'b00, 2'b00, A0, 1));
      tbl.push_back(mk(2'b11, 2'b00, 2'b00, 1'b1, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    end

    rst = 1'b1;
    bus.h_addr     = {A1, A0};
    bus.h_data_out = {WLINE, OLINE};
    bus.m_data_in  = RLINE;
    bus.h_rd = '0; bus.h_wr = '0; bus.h_amo_req = '0; bus.m_dv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    zero_check("reset");
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // AMO lock: hart1 owns the lock, hart0 waits, then takes it two cycles after release
    apply(mk(2'b00, 2'b00, 2'b10, 1'b0, 0, 0, 2'b00, 2'b00, 2'b10, A0, 0));
    apply(mk(2'b11, 2'b00, 2'b10, 1'b0, 1, 0, 2'b00, 2'b00, 2'b10, A1, 0));
    apply(mk(2'b11, 2'b00, 2'b10, 1'b1, 0, 0, 2'b10, 2'b00, 2'b10, A1, 1));
    apply(mk(2'b11, 2'b00, 2'b11, 1'b0, 0, 0, 2'b00, 2'b00, 2'b10, A1, 0));
    apply(mk(2'b11, 2'b00, 2'b11, 1'b0, 1, 0, 2'b00, 2'b00, 2'b10, A1, 0));
    apply(mk(2'b11, 2'b00, 2'b11, 1'b1, 0, 0, 2'b10, 2'b00, 2'b10, A1, 1));
    apply(mk(2'b01, 2'b00, 2'b01, 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    apply(mk(2'b01, 2'b00, 2'b01, 1'b0, 1, 0, 2'b00, 2'b00, 2'b01, A0, 0));
    apply(mk(2'b01, 2'b00, 2'b01, 1'b1, 0, 0, 2'b01, 2'b00, 2'b01, A0, 1));
    apply(mk(2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));

    // Reset mid-read, late m_dv ignored, arbitration restarts from hart0
    apply(mk(2'b01, 2'b00, 2'b00, 1'b0, 1, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    zero_check("mid-read reset");
    rst = 1'b0;
    apply(mk(2'b00, 2'b00, 2'b00, 1'b1, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    apply(mk(2'b11, 2'b00, 2'b00, 1'b0, 1, 0, 2'b00, 2'b00, 2'b00, A0, 0));
    apply(mk(2'b11, 2'b00, 2'b00, 1'b1, 0, 0, 2'b01, 2'b00, 2'b00, A0, 1));
    apply(mk(2'b00, 2'b00, 2'b00, 1'b0, 0, 0, 2'b00, 2'b00, 2'b00, A0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
